// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/reg_4.sv
// MEM/WB pipeline register: updates when enabled, and on a bubble clears
// the register-write enable while every other field holds.
module reg_4 #(
    parameter int Address_Width = 32,
    parameter int Data_Width    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     bubble,
    input  logic                     ld_en,
    input  logic                     reg_write_in,
    input  logic [1:0]               result_src_in,
    input  logic [Address_Width-1:0] alu_result_in,
    input  logic [4:0]               rd_in,
    input  logic [Address_Width-1:0] pc_plus4_in,
    input  logic [Data_Width-1:0]    read_data_in,
    output logic                     reg_write_out,
    output logic [1:0]               result_src_out,
    output logic [Address_Width-1:0] alu_result_out,
    output logic [4:0]               rd_out,
    output logic [Address_Width-1:0] pc_plus4_out,
    output logic [Data_Width-1:0]    read_data_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_out  <= 1'b0;
            result_src_out <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            pc_plus4_out   <= '0;
            read_data_out  <= '0;
        end else if (bubble) begin
            reg_write_out <= 1'b0;
        end else if (en) begin
            reg_write_out  <= reg_write_in;
            result_src_out <= result_src_in;
            alu_result_out <= alu_result_in;
            rd_out         <= rd_in;
            pc_plus4_out   <= pc_plus4_in;
            // Read data only moves when a load actually completes.
            if (ld_en) begin
                read_data_out <= read_data_in;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: runs a request/ready bus handshake for loads
// and stores, stalls the pipeline while busy, and feeds the MEM/WB register.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int Address_Width = 32,
    parameter int Data_Width    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWriteM,
    input  logic [1:0]               ResultSrcM,
    input  logic                     MemWriteM,
    input  logic [Address_Width-1:0] ALUResultM,
    input  logic [Data_Width-1:0]    WriteDataM,
    input  logic [4:0]               RdM,
    input  logic [Address_Width-1:0] PCPlus4M,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [Address_Width-1:0] mem_addr,
    output logic [Data_Width-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [Data_Width-1:0]    mem_rdata,
    output logic                     StallM,
    output logic                     RegWriteW,
    output logic [1:0]               ResultSrcW,
    output logic [Data_Width-1:0]    ReadDataW,
    output logic [Address_Width-1:0] ALUResultW,
    output logic [4:0]               RdW,
    output logic [Address_Width-1:0] PCPlus4W
);

    state_t                   state_reg;
    logic                     mem_req_reg;
    logic                     mem_we_reg;
    logic [Address_Width-1:0] mem_addr_reg;
    logic [Data_Width-1:0]    mem_wdata_reg;
    logic [Data_Width-1:0]    rdata_reg;
    logic                     access;
    logic                     load_done;

    // A store wins over a load select; both still count as an access.
    assign access    = MemWriteM || (ResultSrcM == RESULT_SRC_MEM);
    assign StallM    = ((state_reg == IDLE) && access) || (state_reg == BUSY);
    assign load_done = (state_reg == RESP) && !mem_we_reg;

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        mem_addr_reg  <= {ALUResultM[Address_Width-1:2], 2'b00};
                        mem_wdata_reg <= WriteDataM;
                        mem_we_reg    <= MemWriteM;
                        mem_req_reg   <= 1'b1;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    reg_4 #(
        .Address_Width(Address_Width),
        .Data_Width   (Data_Width)
    ) u_mem_wb (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (!StallM),
        .bubble        (StallM),
        .ld_en         (load_done),
        .reg_write_in  (RegWriteM),
        .result_src_in (ResultSrcM),
        .alu_result_in (ALUResultM),
        .rd_in         (RdM),
        .pc_plus4_in   (PCPlus4M),
        .read_data_in  (rdata_reg),
        .reg_write_out (RegWriteW),
        .result_src_out(ResultSrcW),
        .alu_result_out(ALUResultW),
        .rd_out        (RdW),
        .pc_plus4_out  (PCPlus4W),
        .read_data_out (ReadDataW)
    );

endmodule
